// File: rtl/fp_long_rs.sv
// Reservation station and completion buffer for long-latency FP ops (FDIV/FSQRT).
// Wakes operands from the FPR CDB, dispatches the oldest ready op under credit control, and queues results for the CDB.
module fp_long_rs #(
  parameter int unsigned N_ENTRY   = 4,
  parameter int unsigned TAG_W     = 6,
  parameter int unsigned LAT       = 8,
  parameter int unsigned OUT_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   flush,
  input  logic                   issue_valid,
  output logic                   issue_ready,
  input  logic                   issue_op,
  input  logic [TAG_W-1:0]       issue_tag,
  input  logic [1:0]             opd_valid,
  input  logic [1:0][TAG_W-1:0]  opd_tag,
  input  logic [1:0][31:0]       opd_data,
  input  logic                   cdb_valid,
  input  logic [TAG_W-1:0]       cdb_tag,
  input  logic [31:0]            cdb_data,
  output logic                   core_valid,
  output logic                   core_op,
  output logic [31:0]            core_a,
  output logic [31:0]            core_b,
  input  logic [31:0]            core_result,
  output logic                   cdb_req_valid,
  input  logic                   cdb_req_ready,
  output logic [TAG_W-1:0]       cdb_req_tag,
  output logic [31:0]            cdb_req_data
);

  localparam int unsigned SEL_W = $clog2(N_ENTRY);
  localparam int unsigned CNT_W = $clog2(N_ENTRY + 1);
  localparam int unsigned PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int unsigned CRD_W = $clog2(OUT_DEPTH + 1);

  typedef struct packed {
    logic                  v;
    logic                  op;
    logic [TAG_W-1:0]      tag;
    logic [1:0]            ov;
    logic [1:0][TAG_W-1:0] otag;
    logic [1:0][31:0]      od;
  } ent_t;

  ent_t               r_ent [N_ENTRY];
  ent_t               w_wk  [N_ENTRY];
  ent_t               w_nxt [N_ENTRY];
  ent_t               w_new;
  logic [N_ENTRY-1:0] w_rdy;
  logic [SEL_W-1:0]   w_sel;
  logic               w_any;
  logic               w_disp;
  logic               w_issue;
  logic [CNT_W-1:0]   w_cnt;

  logic [LAT-1:0]     r_inf_v;
  logic [TAG_W-1:0]   r_inf_tag [LAT];

  logic [TAG_W-1:0]   r_fq_tag  [OUT_DEPTH];
  logic [31:0]        r_fq_data [OUT_DEPTH];
  logic [PTR_W-1:0]   r_wr;
  logic [PTR_W-1:0]   r_rd;
  logic [CRD_W-1:0]   r_fcnt;
  logic [CRD_W-1:0]   w_fcnt_nxt;
  logic               r_fvalid;
  logic [CRD_W-1:0]   r_credits;
  logic               w_push;
  logic               w_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OUT_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Oldest ready entry; scanning downward leaves the lowest index selected
  always_comb begin
    w_rdy = '0;
    w_any = 1'b0;
    w_sel = '0;
    for (int i = int'(N_ENTRY) - 1; i >= 0; i--) begin
      w_rdy[i] = r_ent[i].v & (&r_ent[i].ov);
      if (w_rdy[i]) begin
        w_any = 1'b1;
        w_sel = SEL_W'(i);
      end
    end
  end

  assign w_disp      = w_any & (r_credits != '0) & ~flush;
  assign issue_ready = ~r_ent[N_ENTRY-1].v | w_disp;
  assign w_issue     = issue_valid & issue_ready & ~flush;

  assign core_valid  = w_disp;
  assign core_op     = r_ent[w_sel].op;
  assign core_a      = r_ent[w_sel].od[0];
  assign core_b      = r_ent[w_sel].od[1];

  // Occupancy after this cycle's dispatch = slot for the incoming op
  always_comb begin
    w_cnt = '0;
    for (int i = 0; i < int'(N_ENTRY); i++) begin
      w_cnt = w_cnt + CNT_W'(r_ent[i].v);
    end
    if (w_disp) begin
      w_cnt = w_cnt - CNT_W'(1);
    end
  end

  always_comb begin
    w_new      = '0;
    w_new.v    = 1'b1;
    w_new.op   = issue_op;
    w_new.tag  = issue_tag;
    w_new.otag = opd_tag;
    for (int j = 0; j < 2; j++) begin
      if (opd_valid[j] || (j == 1 && issue_op)) begin
        w_new.ov[j] = 1'b1;
        w_new.od[j] = opd_data[j];
      end else if (cdb_valid && opd_tag[j] == cdb_tag) begin
        w_new.ov[j] = 1'b1;
        w_new.od[j] = cdb_data;
      end
    end
  end

  // Wakeup, then remove dispatched entry and shift down, then insert new op
  always_comb begin
    for (int i = 0; i < int'(N_ENTRY); i++) begin
      w_wk[i] = r_ent[i];
      for (int j = 0; j < 2; j++) begin
        if (r_ent[i].v && !r_ent[i].ov[j] && cdb_valid && r_ent[i].otag[j] == cdb_tag) begin
          w_wk[i].ov[j] = 1'b1;
          w_wk[i].od[j] = cdb_data;
        end
      end
    end
    for (int i = 0; i < int'(N_ENTRY) - 1; i++) begin
      w_nxt[i] = (w_disp && SEL_W'(i) >= w_sel) ? w_wk[i+1] : w_wk[i];
    end
    w_nxt[N_ENTRY-1] = w_disp ? '0 : w_wk[N_ENTRY-1];
    for (int i = 0; i < int'(N_ENTRY); i++) begin
      if (w_issue && CNT_W'(i) == w_cnt) begin
        w_nxt[i] = w_new;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(N_ENTRY); i++) r_ent[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < int'(N_ENTRY); i++) r_ent[i] <= '0;
    end else begin
      for (int i = 0; i < int'(N_ENTRY); i++) r_ent[i] <= w_nxt[i];
    end
  end

  // Tags of ops in the core; stage LAT-1 lines up with core_result
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_inf_v <= '0;
      for (int i = 0; i < int'(LAT); i++) r_inf_tag[i] <= '0;
    end else if (flush) begin
      r_inf_v <= '0;
    end else begin
      r_inf_v[0]   <= w_disp;
      r_inf_tag[0] <= r_ent[w_sel].tag;
      for (int i = 1; i < int'(LAT); i++) begin
        r_inf_v[i]   <= r_inf_v[i-1];
        r_inf_tag[i] <= r_inf_tag[i-1];
      end
    end
  end

  assign w_push        = r_inf_v[LAT-1];
  assign w_pop         = r_fvalid & cdb_req_ready;
  assign cdb_req_valid = r_fvalid;
  assign cdb_req_tag   = r_fq_tag[r_rd];
  assign cdb_req_data  = r_fq_data[r_rd];

  always_comb begin
    w_fcnt_nxt = r_fcnt;
    if (w_push && !w_pop) begin
      w_fcnt_nxt = r_fcnt + CRD_W'(1);
    end else if (!w_push && w_pop) begin
      w_fcnt_nxt = r_fcnt - CRD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !flush) begin
      r_fq_tag[r_wr]  <= r_inf_tag[LAT-1];
      r_fq_data[r_wr] <= core_result;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr      <= '0;
      r_rd      <= '0;
      r_fcnt    <= '0;
      r_fvalid  <= 1'b0;
      r_credits <= CRD_W'(OUT_DEPTH);
    end else if (flush) begin
      r_wr      <= '0;
      r_rd      <= '0;
      r_fcnt    <= '0;
      r_fvalid  <= 1'b0;
      r_credits <= CRD_W'(OUT_DEPTH);
    end else begin
      if (w_push) r_wr <= ptr_inc(r_wr);
      if (w_pop)  r_rd <= ptr_inc(r_rd);
      r_fcnt   <= w_fcnt_nxt;
      r_fvalid <= (w_fcnt_nxt != '0);
      if (w_disp && !w_pop) begin
        r_credits <= r_credits - CRD_W'(1);
      end else if (!w_disp && w_pop) begin
        r_credits <= r_credits + CRD_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_fp_long_rs.sv
// Scoreboard bench for fp_long_rs: queue-based RS reference model plus a fixed-latency core model.
module tb_fp_long_rs;
  localparam int unsigned N_ENTRY = 4, TAG_W = 6, LAT = 8, OUT_DEPTH = 4;

  logic clk = 1'b0, reset_n = 1'b0, flush = 1'b0;
  logic issue_valid = 1'b0, issue_ready, issue_op = 1'b0;
  logic [TAG_W-1:0] issue_tag = '0;
  logic [1:0] opd_valid = '0;
  logic [1:0][TAG_W-1:0] opd_tag = '0;
  logic [1:0][31:0] opd_data = '0;
  logic cdb_valid = 1'b0;
  logic [TAG_W-1:0] cdb_tag = '0;
  logic [31:0] cdb_data = '0;
  logic core_valid, core_op;
  logic [31:0] core_a, core_b, core_result;
  logic cdb_req_valid, cdb_req_ready = 1'b0;
  logic [TAG_W-1:0] cdb_req_tag;
  logic [31:0] cdb_req_data;

  int checks = 0, errors = 0, cyc = 0;

  fp_long_rs #(.N_ENTRY(N_ENTRY), .TAG_W(TAG_W), .LAT(LAT), .OUT_DEPTH(OUT_DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .issue_op(issue_op), .issue_tag(issue_tag),
    .opd_valid(opd_valid), .opd_tag(opd_tag), .opd_data(opd_data),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_data(cdb_data),
    .core_valid(core_valid), .core_op(core_op), .core_a(core_a), .core_b(core_b), .core_result(core_result),
    .cdb_req_valid(cdb_req_valid), .cdb_req_ready(cdb_req_ready),
    .cdb_req_tag(cdb_req_tag), .cdb_req_data(cdb_req_data));

  always #5 clk = ~clk;

  function automatic logic [31:0] core_fn(input logic op, input logic [31:0] a, input logic [31:0] b);
    return op ? {a[15:0], ~a[31:16]} : (a - (b ^ 32'h5A5A_0F0F));
  endfunction

  // External core: fixed latency LAT from the dispatch cycle
  logic [31:0] pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= core_valid ? core_fn(core_op, core_a, core_b) : 32'hDEAD_BEEF;
    for (int i = 1; i < int'(LAT); i++) pipe[i] <= pipe[i-1];
  end
  assign core_result = pipe[LAT-1];

  typedef struct {
    logic                  op;
    logic [TAG_W-1:0]      tag;
    logic [1:0]            ov;
    logic [1:0][TAG_W-1:0] ot;
    logic [1:0][31:0]      od;
  } m_ent_t;
  typedef struct { logic [TAG_W-1:0] tag; logic [31:0] data; } exp_t;

  m_ent_t rs[$];
  int     comp_t[$];
  exp_t   exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every accepted CDB request must match the oldest expected completion
  always @(negedge clk) begin
    if (reset_n && cdb_req_valid === 1'b1 && cdb_req_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL cdb_unexpected: got tag %h expected no completion (cycle %0d)", cdb_req_tag, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("cdb_tag", 32'(cdb_req_tag), 32'(e.tag));
        chk("cdb_data", cdb_req_data, e.data);
      end
    end
  end

  // One clock: check combinational/registered outputs against the model, then advance the model
  task automatic step();
    int idx;
    bit disp, exp_ready, exp_rv;
    exp_t e;
    m_ent_t ne;
    @(negedge clk);
    idx = -1;
    if (!flush && comp_t.size() < int'(OUT_DEPTH))
      foreach (rs[i]) if (idx < 0 && rs[i].ov == 2'b11) idx = i;
    disp      = (idx >= 0);
    exp_ready = (rs.size() < int'(N_ENTRY)) || disp;
    exp_rv    = (comp_t.size() > 0) && (comp_t[0] <= cyc);
    if (!flush) chk("issue_ready", 32'(issue_ready), 32'(exp_ready));
    chk("core_valid", 32'(core_valid), 32'(disp));
    if (disp) begin
      chk("core_op", 32'(core_op), 32'(rs[idx].op));
      chk("core_a", core_a, rs[idx].od[0]);
      if (!rs[idx].op) chk("core_b", core_b, rs[idx].od[1]);
    end
    chk("cdb_req_valid", 32'(cdb_req_valid), 32'(exp_rv));
    if (flush) begin
      rs.delete();
      comp_t.delete();
      exp_q.delete();
    end else begin
      if (exp_rv && cdb_req_ready) void'(comp_t.pop_front());
      if (disp) begin
        e.tag  = rs[idx].tag;
        e.data = core_fn(rs[idx].op, rs[idx].od[0], rs[idx].od[1]);
        exp_q.push_back(e);
        comp_t.push_back(cyc + int'(LAT) + 1);
        rs.delete(idx);
      end
      foreach (rs[i])
        for (int j = 0; j < 2; j++)
          if (!rs[i].ov[j] && cdb_valid && rs[i].ot[j] == cdb_tag) begin
            rs[i].ov[j] = 1'b1;
            rs[i].od[j] = cdb_data;
          end
      if (issue_valid && exp_ready) begin
        ne.op  = issue_op;
        ne.tag = issue_tag;
        for (int j = 0; j < 2; j++) begin
          ne.ot[j] = opd_tag[j];
          if (opd_valid[j] || (j == 1 && issue_op)) begin
            ne.ov[j] = 1'b1; ne.od[j] = opd_data[j];
          end else if (cdb_valid && opd_tag[j] == cdb_tag) begin
            ne.ov[j] = 1'b1; ne.od[j] = cdb_data;
          end else begin
            ne.ov[j] = 1'b0; ne.od[j] = '0;
          end
        end
        rs.push_back(ne);
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rr);
    issue_valid = 1'b0; opd_valid = '0; cdb_valid = 1'b0; flush = 1'b0; cdb_req_ready = rr;
  endtask

  task automatic set_issue(input logic op, input logic [TAG_W-1:0] tag, input logic [1:0] ov,
                           input logic [TAG_W-1:0] t0, input logic [TAG_W-1:0] t1,
                           input logic [31:0] d0, input logic [31:0] d1);
    issue_valid = 1'b1; issue_op = op; issue_tag = tag; opd_valid = ov;
    opd_tag[0] = t0; opd_tag[1] = t1; opd_data[0] = d0; opd_data[1] = d1;
  endtask

  task automatic drain(input int n);
    idle(1'b1);
    repeat (n) step();
  endtask

  task automatic rand_inputs(input int p_iss, input bit allow_flush);
    issue_valid = ($urandom_range(99) < p_iss);
    issue_op    = ($urandom_range(3) == 0);
    issue_tag   = TAG_W'($urandom);
    for (int j = 0; j < 2; j++) begin
      opd_valid[j] = 1'($urandom_range(1));
      opd_tag[j]   = TAG_W'($urandom_range(7));
      opd_data[j]  = $urandom;
    end
    cdb_valid     = ($urandom_range(2) == 0);
    cdb_tag       = TAG_W'($urandom_range(7));
    cdb_data      = $urandom;
    cdb_req_ready = ($urandom_range(3) != 0);
    flush         = allow_flush && ($urandom_range(149) == 0);
    if (flush) cdb_req_ready = 1'b0;
  endtask

  task automatic async_reset();
    idle(1'b0);
    reset_n = 1'b0;
    #2;
    chk("rst_issue_ready", 32'(issue_ready), 32'd1);
    chk("rst_core_valid", 32'(core_valid), 32'd0);
    chk("rst_cdb_req_valid", 32'(cdb_req_valid), 32'd0);
    rs.delete(); comp_t.delete(); exp_q.delete();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    async_reset();

    // Single FDIV 6.0 / 2.0 with both operands ready
    set_issue(1'b0, 6'h11, 2'b11, '0, '0, 32'h40C0_0000, 32'h4000_0000);
    cdb_req_ready = 1'b1;
    step();
    drain(LAT + 4);

    // Fill the RS with ops waiting on tag 5, attempt an extra issue, then wake all
    for (int k = 0; k < 4; k++) begin
      set_issue(1'b0, TAG_W'(k + 20), 2'b10, 6'd5, '0, '0, 32'h100 + 32'(k));
      step();
    end
    set_issue(1'b1, 6'h30, 2'b01, '0, '0, 32'h1234_5678, '0);
    step();
    cdb_valid = 1'b1; cdb_tag = 6'd5; cdb_data = 32'h4110_0000;
    step();
    cdb_valid = 1'b0;
    step();
    drain(3 * LAT);

    // Out-of-order readiness: entry0/1 wait on tag 6, entry2 ready, entry3 waits
    set_issue(1'b0, 6'h01, 2'b10, 6'd6, '0, '0, 32'hA);
    step();
    set_issue(1'b0, 6'h02, 2'b10, 6'd6, '0, '0, 32'hB);
    step();
    set_issue(1'b1, 6'h03, 2'b01, '0, '0, 32'hC0DE_0003, '0);
    step();
    set_issue(1'b0, 6'h04, 2'b01, '0, 6'd7, 32'hD, '0);
    step();
    idle(1'b1);
    step();
    cdb_valid = 1'b1; cdb_tag = 6'd7; cdb_data = 32'h7777_0007;
    step();
    cdb_tag = 6'd6; cdb_data = 32'h6666_0006;
    step();
    drain(3 * LAT);

    // Credit stall: no CDB grants, keep offering ready ops
    idle(1'b0);
    for (int k = 0; k < 24; k++) begin
      set_issue(1'b0, TAG_W'(k + 32), 2'b11, '0, '0, $urandom, $urandom);
      step();
    end
    idle(1'b1);
    step();
    idle(1'b0);
    repeat (6) step();
    drain(6 * LAT);

    // Issue-time bypass: opd1 arrives on the CDB in the issue cycle
    set_issue(1'b0, 6'h2A, 2'b01, '0, 6'd3, 32'h4040_0000, '0);
    cdb_valid = 1'b1; cdb_tag = 6'd3; cdb_data = 32'h3FC0_0000;
    step();
    drain(LAT + 4);

    // Flush with one result buffered and two in flight
    idle(1'b0);
    set_issue(1'b0, 6'h3A, 2'b11, '0, '0, 32'h1, 32'h2);
    step();
    idle(1'b0);
    repeat (LAT) step();
    set_issue(1'b0, 6'h3B, 2'b11, '0, '0, 32'h3, 32'h4);
    step();
    set_issue(1'b1, 6'h3C, 2'b11, '0, '0, 32'h5, 32'h6);
    step();
    idle(1'b0);
    step();
    flush = 1'b1;
    step();
    drain(LAT + 4);
    idle(1'b0);
    for (int k = 0; k < 6; k++) begin
      set_issue(1'b0, TAG_W'(k + 8), 2'b11, '0, '0, $urandom, $urandom);
      step();
    end
    drain(3 * LAT);

    // Randomized traffic with sporadic flushes and one asynchronous reset
    for (int k = 0; k < 3000; k++) begin
      rand_inputs(60, 1'b1);
      step();
      if (k == 1500) async_reset();
    end
    drain(8 * LAT + 40);
    for (int k = 0; k < 40; k++) begin
      cdb_valid = 1'b1; cdb_tag = TAG_W'(k % 8); cdb_data = $urandom;
      step();
    end
    drain(8 * LAT + 40);
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
